// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame controller slice.
// Frame layout, peripheral register map, FSM state codes, sizing helper.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic [ADDR_W-1:0] EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] PWM_DUTY    = 7'h04;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_LOW   = 3'd2;
  localparam state_t ST_HIGH  = 3'd3;
  localparam state_t ST_HOLD  = 3'd4;
  localparam state_t ST_GAP   = 3'd5;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

  function automatic int max4(
    int a, int b, int c, int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_frame_controller_if.sv
// Request/status bundle between a config master and spi_frame_controller.
// Signals: req_valid/ready/write/addr/data, busy, done (+rsp_data with SPI_FRAME_CTRL_READBACK_EN).
interface spi_frame_controller_if;
  import spi_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              busy;
  logic              done;
`ifdef SPI_FRAME_CTRL_READBACK_EN
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_write,
    output req_addr, req_data,
    input  req_ready, busy, done,
    input  rsp_data
  );

  modport slave (
    input  req_valid, req_write,
    input  req_addr, req_data,
    output req_ready, busy, done,
    output rsp_data
  );
`else
  modport master (
    output req_valid, req_write,
    output req_addr, req_data,
    input  req_ready, busy, done
  );

  modport slave (
    input  req_valid, req_write,
    input  req_addr, req_data,
    output req_ready, busy, done
  );
`endif

endinterface

// File: rtl/spi_phase_timer.sv
// Loadable down-counter with zero flag; times every FSM phase.
// Ports: clk, rst_n, load_i, val_i (W), zero_o.
module spi_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_frame_controller.sv
// SPI mode-0 writer of 16-bit {rw,addr,data} frames, MSB first.
// Ports: clk, rst_n, bus (slave), sclk/ncs/copi; cipo with SPI_FRAME_CTRL_READBACK_EN.
module spi_frame_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int FRAME_GAP = 4
) (
  input  logic clk,
  input  logic rst_n,
  spi_frame_controller_if.slave bus,
`ifdef SPI_FRAME_CTRL_READBACK_EN
  input  logic cipo,
`endif
  output logic sclk,
  output logic ncs,
  output logic copi
);

  localparam int TMAX =
    max4(CLK_DIV, CS_SETUP, CS_HOLD, FRAME_GAP);
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] LD_DIV  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] LD_SET  = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] LD_HOLD = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0] LD_GAP  = TW'(FRAME_GAP - 1);

  state_t         state_q, state_d;
  logic [15:0]    sh_q, sh_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           ld;
  logic [TW-1:0]  ld_val;
  logic           tmr_zero;
  logic           active;
  logic           ready_q, busy_q, fin_q, done_q;
  logic           sclk_q, ncs_q, copi_q;
  frame_t         req_f;

  assign req_f = '{bus.req_write, bus.req_addr, bus.req_data};

  spi_phase_timer #(.W(TW)) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ld),
    .val_i  (ld_val),
    .zero_o (tmr_zero)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    ld_val  = '0;
    unique case (state_q)
      ST_IDLE: if (bus.req_valid) begin
        sh_d    = req_f;
        cnt_d   = 4'd0;
        state_d = ST_SETUP;
        ld      = 1'b1;
        ld_val  = LD_SET;
      end
      ST_SETUP, ST_LOW: if (tmr_zero) begin
        state_d = (state_q == ST_LOW) ? ST_HIGH : ST_LOW;
        ld      = 1'b1;
        ld_val  = LD_DIV;
      end
      ST_HIGH: if (tmr_zero) begin
        ld = 1'b1;
        if (cnt_q == 4'd15) begin
          state_d = ST_HOLD;
          ld_val  = LD_HOLD;
        end else begin
          state_d = ST_LOW;
          ld_val  = LD_DIV;
          cnt_d   = cnt_q + 4'd1;
          sh_d    = {sh_q[14:0], 1'b0};
        end
      end
      ST_HOLD: if (tmr_zero) begin
        state_d = ST_GAP;
        ld      = 1'b1;
        ld_val  = LD_GAP;
      end
      ST_GAP: if (tmr_zero) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign active = (state_q == ST_SETUP) || (state_q == ST_LOW)
               || (state_q == ST_HIGH)  || (state_q == ST_HOLD);

  // Pins follow state_q one cycle late, so nCS falls the cycle
  // after the accept edge and done lines up with the nCS rise.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
      fin_q   <= (state_q == ST_HOLD) && tmr_zero;
      done_q  <= fin_q;
      sclk_q  <= (state_q == ST_HIGH);
      ncs_q   <= !active;
      copi_q  <= active && sh_q[15];
    end

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign sclk          = sclk_q;
  assign ncs           = ncs_q;
  assign copi          = copi_q;

`ifdef SPI_FRAME_CTRL_READBACK_EN
  logic [7:0] rx_q, rsp_q;

  // Data-phase bits (bit_cnt 8..15) sampled at the end of HIGH.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_q  <= '0;
      rsp_q <= '0;
    end else begin
      if (state_q == ST_HIGH && tmr_zero && cnt_q[3])
        rx_q <= {rx_q[6:0], cipo};
      if (fin_q)
        rsp_q <= rx_q;
    end

  assign bus.rsp_data = rsp_q;
`endif

endmodule

// File: tb/tb_spi_frame_controller.sv
// Directed bench for spi_frame_controller with a bus-level SPI monitor.
// The monitor rebuilds frames from the pins and keeps a register model.
module tb_spi_frame_controller;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk, ncs, copi;

  spi_frame_controller_if bus();

`ifdef SPI_FRAME_CTRL_READBACK_EN
  logic cipo = 1'b0;
  logic [15:0] cipo_pat = 16'h003C;
  int rk = 0;
  logic [7:0] last_rsp = '0;
`endif

  spi_frame_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
`ifdef SPI_FRAME_CTRL_READBACK_EN
    .cipo  (cipo),
`endif
    .sclk  (sclk),
    .ncs   (ncs),
    .copi  (copi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  int cyc = 0;
  int acc_cyc = 0, n_acc = 0, n_done = 0;
  int last_lat = 0, low_cnt = 0, last_low = 0;
  int hi_cnt = 0, last_hi = 0, nbits = 0, n_abort = 0;
  logic [15:0] rx = '0;
  logic [15:0] frames[$];
  logic [7:0] regs[0:127];
  logic ncs_p = 1'b1, sclk_p = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.req_valid && bus.req_ready && rst_n) begin
      acc_cyc = cyc + 1;
      n_acc++;
    end
    if (bus.done) begin
      n_done++;
      last_lat = cyc - acc_cyc;
`ifdef SPI_FRAME_CTRL_READBACK_EN
      last_rsp = bus.rsp_data;
`endif
    end
    if (!ncs) begin
      if (ncs_p) begin
        last_hi = hi_cnt;
        low_cnt = 1;
        nbits = 0;
        rx = '0;
      end else low_cnt++;
      if (sclk && !sclk_p) begin
        rx = {rx[14:0], copi};
        nbits++;
      end
    end else begin
      if (!ncs_p) begin
        last_low = low_cnt;
        hi_cnt = 1;
        if (nbits == 16) begin
          frames.push_back(rx);
          if (rx[15]) regs[rx[14:8]] = rx[7:0];
        end else n_abort++;
      end else hi_cnt++;
    end
    ncs_p = ncs;
    sclk_p = sclk;
  end

`ifdef SPI_FRAME_CTRL_READBACK_EN
  always @(negedge ncs) rk = 0;
  always @(posedge sclk) begin
    #1;
    if (rk < 16) cipo = cipo_pat[15-rk];
    rk++;
  end
`endif

  task automatic send(
    input logic w,
    input logic [6:0] a,
    input logic [7:0] d
  );
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_data  = d;
    while (!bus.req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~w;
    bus.req_addr  = ~a;
    bus.req_data  = ~d;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || !bus.req_ready) && n < 500);
    if (n >= 500) check("idle_timeout", 0, 1);
  endtask

  task automatic frame_chk(
    input string tag,
    input int nf,
    input logic [15:0] exp
  );
    check({tag, "_nframes"}, frames.size(), nf);
    if (frames.size() > 0)
      check({tag, "_bits"}, {16'h0, frames[$]}, {16'h0, exp});
    check({tag, "_ncs_low"}, last_low, 132);
    check({tag, "_latency"}, last_lat, 133);
  endtask

  int nf, a0, d0, ab0;

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = '0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_ncs",   ncs, 1);
    check("rst_sclk",  sclk, 0);
    check("rst_copi",  copi, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_busy",  bus.busy, 0);
    check("rst_done",  bus.done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single write, default timing
    d0 = n_done;
    send(1'b1, PWM_DUTY, 8'h80);
    wait_idle();
    frame_chk("wr_duty80", 1, 16'h8480);
    check("wr_duty80_done", n_done - d0, 1);
    check("wr_duty80_reg", regs[4], 8'h80);

    // register loopback through the model
    send(1'b1, EN_OUT_7_0, 8'hA5);
    wait_idle();
    frame_chk("wr_out", 2, 16'h80A5);
    send(1'b1, PWM_DUTY, 8'h40);
    wait_idle();
    frame_chk("wr_duty40", 3, 16'h8440);
    check("reg_out70", regs[0], 8'hA5);
    check("reg_duty",  regs[4], 8'h40);
    check("reg_out158", regs[1], 8'h00);
    check("reg_pwm70",  regs[2], 8'h00);
    check("reg_pwm158", regs[3], 8'h00);

    // req_valid held: second request only after the gap
    a0 = n_acc;
    d0 = n_done;
    nf = frames.size();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = EN_PWM_15_8;
    bus.req_data  = 8'h11;
    @(posedge clk);
    #1;
    bus.req_addr = EN_OUT_15_8;
    bus.req_data = 8'h22;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (n >= 400) check("b2b_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_idle();
    check("b2b_accepts", n_acc - a0, 2);
    check("b2b_dones", n_done - d0, 2);
    check("b2b_nframes", frames.size(), nf + 2);
    if (frames.size() >= 2) begin
      check("b2b_first", {16'h0, frames[frames.size()-2]},
            32'h8311);
      check("b2b_second", {16'h0, frames[$]}, 32'h8122);
    end
    check("b2b_gap", last_hi, 5);

    // async reset during bit 7 HIGH
    ab0 = n_abort;
    nf = frames.size();
    send(1'b1, EN_PWM_7_0, 8'h77);
    begin
      int n;
      n = 0;
      while (nbits != 8 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (n >= 400) check("bit7_timeout", 0, 1);
    end
    check("pre_rst_sclk", sclk, 1);
    rst_n = 1'b0;
    #1;
    check("abort_ncs",   ncs, 1);
    check("abort_sclk",  sclk, 0);
    check("abort_copi",  copi, 0);
    check("abort_ready", bus.req_ready, 1);
    check("abort_busy",  bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_count", n_abort - ab0, 1);
    check("abort_reg", regs[2], 8'h00);
    check("abort_ready2", bus.req_ready, 1);
    send(1'b1, EN_PWM_7_0, 8'h5A);
    wait_idle();
    frame_chk("post_rst", nf + 1, 16'h825A);
    check("post_rst_reg", regs[2], 8'h5A);

    // read frame: bit 15 low, no register change
    send(1'b0, EN_OUT_15_8, 8'h33);
    wait_idle();
    frame_chk("rd", nf + 2, 16'h0133);
    check("rd_reg", regs[1], 8'h22);

`ifdef SPI_FRAME_CTRL_READBACK_EN
    send(1'b1, PWM_DUTY, 8'h00);
    wait_idle();
    check("rsp_at_done", last_rsp, 8'h3C);
    check("rsp_hold", bus.rsp_data, 8'h3C);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
